pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_pattern_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// pattern_gen: timed LED pattern sequencer.
//
// On start, the block takes a snapshot of the timing, repetition, pattern and
// mode inputs. It then plays ON/OFF repetitions on the LED channels. In chase
// mode the pattern rotates left by one channel at every repetition boundary.
// In loop mode the block ignores the repetition count and runs until stop.
// All outputs come straight from flops.
//
// Ports:
//   hwclk   - sole clock, rising edge
//   rst     - synchronous active-high reset
//   start   - begin a pattern (accepted only in IDLE, and only with stop=0)
//   stop    - abort request, honoured in every state
//   ontime  - ON phase length in cycles (0 is treated as 1)
//   offtime - OFF phase length in cycles (0 skips the OFF phase)
//   reps    - number of ON+OFF repetitions
//   mask    - initial LED pattern
//   mode    - bit0 chase, bit1 loop
//   leds    - registered LED drive
//   busy    - high while in ON or OFF
//   done    - one-cycle pulse on normal completion
module pattern_gen #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 32,
    parameter int REP_W    = 8
) (
    input  logic                hwclk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [CNT_W-1:0]    ontime,
    input  logic [CNT_W-1:0]    offtime,
    input  logic [REP_W-1:0]    reps,
    input  logic [CHANNELS-1:0] mask,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] leds,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [REP_W-1:0]    REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0]    REP_ONE  = REP_W'(1);
    localparam logic [CHANNELS-1:0] PAT_ZERO = {CHANNELS{1'b0}};

    // Rotate left by one channel; the MSB wraps into the LSB.
    function automatic logic [CHANNELS-1:0] rotl1(input logic [CHANNELS-1:0] p);
        logic [CHANNELS-1:0] r;
        r = p;
        for (int i = 0; i < CHANNELS; i++) begin
            r[(i + 1) % CHANNELS] = p[i];
        end
        return r;
    endfunction

    state_t              state_r,   state_nx_s;
    logic [CNT_W-1:0]    ontime_r,  ontime_nx_s;
    logic [CNT_W-1:0]    offtime_r, offtime_nx_s;
    logic [REP_W-1:0]    reps_r,    reps_nx_s;
    logic [1:0]          mode_r,    mode_nx_s;
    logic [CHANNELS-1:0] pattern_r, pattern_nx_s;
    logic [CNT_W-1:0]    phase_r,   phase_nx_s;
    logic [REP_W-1:0]    rep_cnt_r, rep_cnt_nx_s;
    logic [CHANNELS-1:0] leds_r,    leds_nx_s;
    logic                busy_r,    busy_nx_s;
    logic                done_r,    done_nx_s;

    logic [CNT_W-1:0]    on_last_s;
    logic [CNT_W-1:0]    off_last_s;
    logic [REP_W-1:0]    rep_inc_s;
    logic                rep_boundary_s;

    // Terminal counts: phases count 0..N-1, so a length of all-ones cannot overflow.
    always_comb begin
        on_last_s  = CNT_ZERO;
        off_last_s = offtime_r - CNT_ONE;
        rep_inc_s  = rep_cnt_r + REP_ONE;
        if (ontime_r == CNT_ZERO) begin
            on_last_s = CNT_ZERO;
        end else begin
            on_last_s = ontime_r - CNT_ONE;
        end
    end

    // Next-state, counter, latch and registered-output computation.
    always_comb begin
        state_nx_s     = state_r;
        ontime_nx_s    = ontime_r;
        offtime_nx_s   = offtime_r;
        reps_nx_s      = reps_r;
        mode_nx_s      = mode_r;
        pattern_nx_s   = pattern_r;
        phase_nx_s     = phase_r;
        rep_cnt_nx_s   = rep_cnt_r;
        rep_boundary_s = 1'b0;
        leds_nx_s      = PAT_ZERO;
        busy_nx_s      = 1'b0;
        done_nx_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    ontime_nx_s  = ontime;
                    offtime_nx_s = offtime;
                    reps_nx_s    = reps;
                    mode_nx_s    = mode;
                    pattern_nx_s = mask;
                    phase_nx_s   = CNT_ZERO;
                    rep_cnt_nx_s = REP_ZERO;
                    if ((reps == REP_ZERO) && !mode[1]) begin
                        state_nx_s = ST_FIN;
                    end else begin
                        state_nx_s = ST_ON;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ON: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (phase_r == on_last_s) begin
                    phase_nx_s = CNT_ZERO;
                    if (offtime_r != CNT_ZERO) begin
                        state_nx_s = ST_OFF;
                    end else begin
                        rep_boundary_s = 1'b1;
                    end
                end else begin
                    phase_nx_s = phase_r + CNT_ONE;
                end
            end
            ST_OFF: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (phase_r == off_last_s) begin
                    phase_nx_s     = CNT_ZERO;
                    rep_boundary_s = 1'b1;
                end else begin
                    phase_nx_s = phase_r + CNT_ONE;
                end
            end
            ST_FIN: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        // End of a repetition: count it, then either finish or start the next ON.
        // In loop mode the counter simply wraps and never ends the pattern.
        if (rep_boundary_s) begin
            rep_cnt_nx_s = rep_inc_s;
            if (!mode_r[1] && (rep_inc_s == reps_r)) begin
                state_nx_s = ST_FIN;
            end else begin
                state_nx_s = ST_ON;
                if (mode_r[0]) begin
                    pattern_nx_s = rotl1(pattern_r);
                end else begin
                    pattern_nx_s = pattern_r;
                end
            end
        end else begin
            rep_cnt_nx_s = rep_cnt_nx_s;
        end

        // Outputs are decoded from the next state so they line up with it after the edge.
        if (state_nx_s == ST_ON) begin
            leds_nx_s = pattern_nx_s;
        end else begin
            leds_nx_s = PAT_ZERO;
        end
        busy_nx_s = (state_nx_s == ST_ON) || (state_nx_s == ST_OFF);
        done_nx_s = (state_nx_s == ST_FIN);
    end

    // State, latched parameters, counters and output registers.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ontime_r  <= CNT_ZERO;
            offtime_r <= CNT_ZERO;
            reps_r    <= REP_ZERO;
            mode_r    <= 2'b00;
            pattern_r <= PAT_ZERO;
            phase_r   <= CNT_ZERO;
            rep_cnt_r <= REP_ZERO;
            leds_r    <= PAT_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            ontime_r  <= ontime_nx_s;
            offtime_r <= offtime_nx_s;
            reps_r    <= reps_nx_s;
            mode_r    <= mode_nx_s;
            pattern_r <= pattern_nx_s;
            phase_r   <= phase_nx_s;
            rep_cnt_r <= rep_cnt_nx_s;
            leds_r    <= leds_nx_s;
            busy_r    <= busy_nx_s;
            done_r    <= done_nx_s;
        end
    end

    assign leds = leds_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed self-checking bench for pattern_gen (CHANNELS=8).
// Each task drives one scenario and compares {leds,busy,done} cycle by cycle
// against hand-derived expectations. Outputs are sampled 1ns after each rising edge.
module tb_pattern_gen;

    logic        hwclk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [31:0] ontime;
    logic [31:0] offtime;
    logic [7:0]  reps;
    logic [7:0]  mask;
    logic [1:0]  mode;
    logic [7:0]  leds;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    pattern_gen #(.CHANNELS(8), .CNT_W(32), .REP_W(8)) dut (
        .hwclk   (hwclk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .ontime  (ontime),
        .offtime (offtime),
        .reps    (reps),
        .mask    (mask),
        .mode    (mode),
        .leds    (leds),
        .busy    (busy),
        .done    (done)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        ontime = 32'd0; offtime = 32'd0; reps = 8'd0; mask = 8'h00; mode = 2'b00;
        step();
        step();
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset leds/busy/done got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_idle leds/busy/done got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
    endtask

    // 81 / on 4 / off 2 / 3 reps. With perturb set, a second start with different
    // inputs is pulsed mid-run and must not change anything.
    task automatic test_basic_timing(input bit perturb);
        logic [7:0] el;
        mask = 8'h81; ontime = 32'd4; offtime = 32'd2; reps = 8'd3; mode = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            el = (((c - 1) % 6) < 4) ? 8'h81 : 8'h00;
            checks++;
            if ({leds, busy, done} !== {el, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL basic p=%0d c=%0d leds/busy/done got=%h/%b/%b exp=%h/1/0",
                         perturb, c, leds, busy, done, el);
            end
            if (perturb && (c == 3)) begin
                start = 1'b1; mask = 8'hff; ontime = 32'd1; offtime = 32'd0;
                reps = 8'd1; mode = 2'b11;
            end else if (perturb && (c == 4)) begin
                start = 1'b0;
            end
            step();
        end
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL basic_done p=%0d got=%h/%b/%b exp=00/0/1", perturb, leds, busy, done);
        end
        step();
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_idle p=%0d got=%h/%b/%b exp=00/0/0", perturb, leds, busy, done);
        end
        start = 1'b0;
    endtask

    // Chase: 01 / on 2 / off 1 / 4 reps -> ON patterns 01,02,04,08.
    task automatic test_chase();
        logic [7:0] pats [4];
        logic [7:0] el;
        pats = '{8'h01, 8'h02, 8'h04, 8'h08};
        mask = 8'h01; ontime = 32'd2; offtime = 32'd1; reps = 8'd4; mode = 2'b01;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            el = (((c - 1) % 3) < 2) ? pats[(c - 1) / 3] : 8'h00;
            checks++;
            if ({leds, busy, done} !== {el, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL chase c=%0d got=%h/%b/%b exp=%h/1/0", c, leds, busy, done, el);
            end
            step();
        end
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL chase_done got=%h/%b/%b exp=00/0/1", leds, busy, done);
        end
        step();
    endtask

    // Loop mode with reps=0: toggles every cycle until stop at cycle 300, no done.
    task automatic test_loop_stop();
        logic [7:0] el;
        mask = 8'h5a; ontime = 32'd1; offtime = 32'd1; reps = 8'd0; mode = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 299; c++) begin
            el = ((c % 2) == 1) ? 8'h5a : 8'h00;
            checks++;
            if ({leds, busy, done} !== {el, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL loop c=%0d got=%h/%b/%b exp=%h/1/0", c, leds, busy, done, el);
            end
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL loop_stop got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
        step();
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL loop_after_stop got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
    endtask

    // Loop+chase with offtime=0: rotation wraps MSB into LSB and runs past reps.
    task automatic test_loop_chase();
        logic [7:0] tab [10];
        tab = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        mask = 8'h80; ontime = 32'd1; offtime = 32'd0; reps = 8'd5; mode = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({leds, busy, done} !== {tab[c], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL loop_chase c=%0d got=%h/%b/%b exp=%h/1/0", c, leds, busy, done, tab[c]);
            end
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL loop_chase_stop got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
    endtask

    // ontime=0/offtime=0/reps=2 and reps=0 immediate finish.
    task automatic test_edges();
        mask = 8'hc3; ontime = 32'd0; offtime = 32'd0; reps = 8'd2; mode = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if ({leds, busy, done} !== {8'hc3, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL edge_on0 c=%0d got=%h/%b/%b exp=c3/1/0", c, leds, busy, done);
            end
            step();
        end
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL edge_on0_done got=%h/%b/%b exp=00/0/1", leds, busy, done);
        end
        step();
        reps = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL edge_reps0 got=%h/%b/%b exp=00/0/1", leds, busy, done);
        end
        step();
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL edge_reps0_idle got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
    endtask

    // Start accepted in the IDLE cycle right after FIN.
    task automatic test_back_to_back();
        mask = 8'h11; ontime = 32'd3; offtime = 32'd0; reps = 8'd0; mode = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        mask = 8'h3c; ontime = 32'd1; reps = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({leds, busy, done} !== {8'h3c, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_on got=%h/%b/%b exp=3c/1/0", leds, busy, done);
        end
        step();
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL b2b_done got=%h/%b/%b exp=00/0/1", leds, busy, done);
        end
        step();
    endtask

    // Start with stop in IDLE is ignored.
    task automatic test_start_stop_idle();
        mask = 8'hff; ontime = 32'd2; offtime = 32'd2; reps = 8'd1; mode = 2'b00;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL start_stop_idle got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
        step();
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL start_stop_idle2 got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
    endtask

    // rst during the OFF phase of rep 2 (cycle 11), then a full clean run.
    task automatic test_reset_mid();
        mask = 8'h81; ontime = 32'd4; offtime = 32'd2; reps = 8'd3; mode = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
        end
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid_pre got=%h/%b/%b exp=00/1/0", leds, busy, done);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid got=%h/%b/%b exp=00/0/0", leds, busy, done);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({leds, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rst_mid_quiet c=%0d got=%h/%b/%b exp=00/0/0", c, leds, busy, done);
            end
        end
        test_basic_timing(1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_timing(1'b0);
        test_chase();
        test_loop_stop();
        test_loop_chase();
        test_edges();
        test_back_to_back();
        test_start_stop_idle();
        test_basic_timing(1'b1);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
